// File: rtl/mem_fill_responder.sv
// Fixed-latency word memory responder for cache fills: single-port storage
// feeding a LATENCY-deep {valid, data} shift register that returns read data.
module mem_fill_responder #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int LATENCY   = 4,
  parameter int MEM_WORDS = 32768
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy
);

  // Handshake: a request is taken on every rising edge where enable is high
  // (no ready, no stall). Each read returns exactly one data_valid pulse
  // LATENCY cycles after its request cycle; writes never return anything.

  localparam int IDX_W = ADDR_W - 1;

  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [IDX_W-1:0]  idx;
  logic              rd_req;
  logic              wr_req;
  logic              unused_addr_lsb;

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [DATA_W-1:0]  dat_q [LATENCY];
  logic [DATA_W-1:0]  dat_d [LATENCY];

  assign idx             = addr[ADDR_W-1:1];
  assign unused_addr_lsb = addr[0];
  assign rd_req          = enable & ~wr;
  assign wr_req          = enable & wr;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_req) begin
      mem[idx] <= data_in;
    end
  end

  // Stage data only moves when a valid entry moves, so the final stage keeps
  // its last returned word while bubbles pass through.
  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = rd_req;
    dat_d[0] = rd_req ? mem[idx] : dat_q[0];
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign data_valid = vld_q[LATENCY-1];
  assign data_out   = dat_q[LATENCY-1];
  assign busy       = |vld_q;

endmodule

// File: tb/tb_mem_fill_responder.sv
// Directed bench for mem_fill_responder: drivers push {return cycle, data}
// into an expected queue; a negedge monitor pops and checks every pulse.
module tb_mem_fill_responder;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int LATENCY   = 4;
  localparam int MEM_WORDS = 32768;
  localparam int W         = 32 + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              wr = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              busy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int last_issue = 0;
  int c = 0;

  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] model [int];

  mem_fill_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LATENCY), .MEM_WORDS(MEM_WORDS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .data_valid(data_valid), .busy(busy)
  );

  // Clock / cycle counter: cycle k starts at the k-th rising edge.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  // Driver tasks: inputs change on the falling edge.
  task automatic req(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    enable = 1'b1;
    wr = w;
    addr = a;
    data_in = d;
    last_issue = cyc;
    if (w) model[int'(a >> 1)] = d;
    else exp_q.push_back({32'(cyc + LATENCY), model[int'(a >> 1)]});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      enable = 1'b0;
      wr = 1'b0;
    end
  endtask

  task automatic wait_until(input int t);
    do begin
      @(negedge clk);
      enable = 1'b0;
      wr = 1'b0;
    end while (cyc < t);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: data_valid=1 data_out=%h with nothing expected (cycle %0d)",
                 data_out, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), e[W-1:DATA_W]);
        check("pulse_data", {16'h0, data_out}, {16'h0, e[DATA_W-1:0]});
      end
    end
  end

  initial begin
    #12;
    check("reset_data_valid", {31'h0, data_valid}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_data_out", {16'h0, data_out}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Write then read two cycles later.
    req(1'b1, 16'h0040, 16'hBEEF);
    idle(1);
    req(1'b0, 16'h0040, 16'h0);
    idle(6);

    // Burst of eight reads.
    for (int i = 0; i < 8; i++) req(1'b1, 16'(16'h1000 + 2 * i), 16'(i));
    req(1'b0, 16'h1000, 16'h0);
    c = last_issue;
    for (int i = 1; i < 8; i++) req(1'b0, 16'(16'h1000 + 2 * i), 16'h0);
    wait_until(c + 11);
    check("burst_busy_last_pulse", {31'h0, busy}, 32'h1);
    check("burst_valid_last_pulse", {31'h0, data_valid}, 32'h1);
    wait_until(c + 12);
    check("burst_busy_after", {31'h0, busy}, 32'h0);
    check("burst_valid_after", {31'h0, data_valid}, 32'h0);
    check("burst_data_hold", {16'h0, data_out}, 32'h7);
    idle(2);

    // Snapshot: write right after read does not change the in-flight read.
    req(1'b1, 16'h0020, 16'h1111);
    idle(2);
    req(1'b0, 16'h0020, 16'h0);
    req(1'b1, 16'h0020, 16'h2222);
    idle(1);
    req(1'b0, 16'h0020, 16'h0);
    idle(6);

    // Read, write, read: pulses 1,0,1.
    req(1'b1, 16'h0050, 16'hAAAA);
    req(1'b1, 16'h0060, 16'h5555);
    req(1'b0, 16'h0050, 16'h0);
    req(1'b1, 16'h0070, 16'h0001);
    req(1'b0, 16'h0060, 16'h0);
    idle(6);

    // Odd address aliasing and top-of-memory wrap.
    req(1'b1, 16'h0042, 16'hA5A5);
    req(1'b0, 16'h0043, 16'h0);
    req(1'b1, 16'hFFFE, 16'h7E7E);
    req(1'b1, 16'h0000, 16'h1234);
    req(1'b0, 16'hFFFF, 16'h0);
    req(1'b0, 16'hFFFE, 16'h0);
    req(1'b0, 16'h0001, 16'h0);
    idle(8);

    // Asynchronous reset with two reads in flight.
    req(1'b0, 16'h0040, 16'h0);
    c = last_issue;
    req(1'b0, 16'h0042, 16'h0);
    wait_until(c + 3);
    check("pre_reset_busy", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #1;
    check("pre_reset_pulse", {31'h0, data_valid}, 32'h1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_valid", {31'h0, data_valid}, 32'h0);
    check("async_reset_busy", {31'h0, busy}, 32'h0);
    check("async_reset_data", {16'h0, data_out}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    check("post_reset_busy", {31'h0, busy}, 32'h0);
    req(1'b0, 16'h0040, 16'h0);
    idle(8);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_fill_responder.md
Name: mem_fill_responder

Overview:
- Pipelined, fixed-latency memory responder: the memory side of the cache fill protocol.
- Accepts one word read or write per cycle. Returns read data after LATENCY cycles, with data_valid high for exactly one cycle per read.
- Sits between the cache fill controllers (I- and D-cache) and the backing store. Models the multi-cycle main memory that the fill FSM's memory_data_valid handshake expects.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width.
- LATENCY, 4, cycles from read acceptance to data_valid; legal range 1..8.
- MEM_WORDS, 32768, storage depth in words; equals 2^(ADDR_W-1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  request strobe; one request is accepted per cycle while high.
- wr  in  1  qualifies enable: 1 = write, 0 = read.
- addr  in  ADDR_W  byte address; bit 0 is ignored (word-aligned).
- data_in  in  DATA_W  write data, sampled with enable&wr.
- data_out  out  DATA_W  read data, valid when data_valid is high.
- data_valid  out  1  one-cycle pulse per completed read.
- busy  out  1  high while any read is in flight (pipeline stage occupied).

Behaviour:
- Reset (rst_n low, asynchronous):
  - All pipeline valid bits clear, data_out=0, data_valid=0, busy=0.
  - Storage array is NOT reset.
  - In-flight reads are discarded and never return.
- Write (enable&wr):
  - mem[addr[ADDR_W-1:1]] <= data_in at the clock edge.
  - Produces no response and does not occupy the pipeline.
- Read (enable&~wr):
  - Array word mem[addr[ADDR_W-1:1]] is sampled at the acceptance edge into stage 1 along with valid=1.
  - The data is a snapshot: a write to the same address in any later cycle does not alter an in-flight read.
- Pipeline:
  - LATENCY-stage shift register of {valid, data}; every stage advances every cycle. There is no stall and no backpressure.
  - Read accepted at edge N: data_valid=1 and data_out=word in the cycle after edge N+LATENCY-1, i.e. registered outputs change at edge N+LATENCY-1. For LATENCY=4, acceptance at cycle 0 gives data_valid during cycle 4.
- Outputs:
  - data_valid and data_out come straight from the final stage register.
  - When the final stage is invalid, data_out holds its previous value (not forced to 0).
- Throughput:
  - Back-to-back reads on consecutive cycles return on consecutive cycles, in issue order.
  - Eight consecutive reads give eight consecutive data_valid pulses.
- Mixed streams: a write interleaved between reads creates a one-cycle gap in the data_valid pulse train at the matching position.
- busy = OR of all stage valid bits, including the final stage. It drops the cycle after the last data_valid.
- enable low: pipeline keeps draining; no new entries.
- Address wrap: addr=16'hFFFE maps to word 32767. Odd addresses alias to the even word below them.
- Storage is a single port; simultaneous read and write cannot occur.
- Reset released mid-stream: the first request after deassertion is handled normally. No stale data_valid appears.

Test Plan:
- Write 16'hBEEF to addr 16'h0040, then read 16'h0040 at cycle 2 -> data_valid=1 and data_out=16'hBEEF in exactly cycle 6 only (LATENCY=4).
- Preload words 0x1000..0x100E with values 0..7, then issue eight consecutive reads -> eight consecutive data_valid pulses, values 0..7 in order; busy falls the cycle after the eighth pulse.
- Read 16'h0020 holding 16'h1111, then write 16'h2222 to 16'h0020 next cycle -> returned data is 16'h1111; a later read returns 16'h2222.
- Sequence read, write, read -> pulse pattern 1,0,1 starting LATENCY cycles after the first read.
- Two reads in flight, then assert rst_n=0 asynchronously mid-cycle -> data_valid and busy drop immediately; neither read returns after release.
- Odd address 16'h0043 read after writing 16'hA5A5 to 16'h0042 -> returns 16'hA5A5; address 16'hFFFF read returns mem[32767].
